// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: address widths,
// opcode encodings, FSM state type and an instruction-length decoder.
package cpu_pkg;

    localparam int RAM_AW  = 13;
    localparam int VRAM_AW = 10;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_LDA_IMM = 8'h01;
    localparam logic [7:0] OP_LDA_ABS = 8'h02;
    localparam logic [7:0] OP_STA     = 8'h03;
    localparam logic [7:0] OP_ADD     = 8'h04;
    localparam logic [7:0] OP_SUB     = 8'h05;
    localparam logic [7:0] OP_JMP     = 8'h06;
    localparam logic [7:0] OP_JNZ     = 8'h07;
    localparam logic [7:0] OP_JC      = 8'h08;
    localparam logic [7:0] OP_STV     = 8'h09;
    localparam logic [7:0] OP_WVS     = 8'h0A;
    localparam logic [7:0] OP_LDX     = 8'h0B;
    localparam logic [7:0] OP_INX     = 8'h0C;
    localparam logic [7:0] OP_STVX    = 8'h0D;
    localparam logic [7:0] OP_HLT     = 8'hFF;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_OPERAND = 3'd2,
        ST_MEMRD   = 3'd3,
        ST_EXEC    = 3'd4,
        ST_WAITVS  = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    // Number of operand bytes following an opcode (undefined opcodes take none).
    function automatic logic [1:0] op_len(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_ADD, OP_SUB, OP_LDX:                  op_len = 2'd1;
            OP_LDA_ABS, OP_STA, OP_JMP, OP_JNZ, OP_JC,
            OP_STV, OP_STVX:                                     op_len = 2'd2;
            default:                                             op_len = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_core_vsync_sync.sv
// Brings the LCD frame sync into the clk domain and produces a one-cycle
// pulse on each rising edge.
module vsync_sync (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic vs_rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic rise_r;

    // Two-flop synchronizer followed by a registered rising-edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            meta_r <= vsync;
            sync_r <= meta_r;
            prev_r <= sync_r;
            rise_r <= sync_r & ~prev_r;
        end
    end

    assign vs_rise = rise_r;

endmodule

// File: rtl/cpu_core.sv
// 8-bit accumulator CPU: copies the boot image into program RAM, then
// fetches and executes from it, writing characters into VRAM.
// Every RAM read is a two-cycle request/data pair; all outputs are registered.
module cpu_core #(
    parameter int BOOT_MAX = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            dout,
    input  logic                  vsync,
    input  logic [8*BOOT_MAX-1:0] boot_program,
    input  logic [15:0]           boot_program_length,
    output logic [7:0]            din,
    output logic [12:0]           ada,
    output logic                  cea,
    output logic                  ceb,
    output logic [12:0]           adb,
    output logic [9:0]            v_ada,
    output logic                  v_cea,
    output logic [7:0]            v_din,
    output logic                  halted
);

    import cpu_pkg::*;

    state_e              state_r, state_s;
    logic                phase_r, phase_s;        // 0: read request cycle, 1: data cycle
    logic                opnd_idx_r, opnd_idx_s;  // which operand byte is in flight
    logic [RAM_AW-1:0]   pc_r, pc_s;
    logic [7:0]          a_r, a_s;
    logic [7:0]          x_r, x_s;
    logic                z_r, z_s;
    logic                c_r, c_s;
    logic [15:0]         boot_cnt_r, boot_cnt_s;
    logic [7:0]          opcode_r, opcode_s;
    logic [7:0]          lo_r, lo_s;
    logic [4:0]          hi_r, hi_s;
    logic                vs_seen_r, vs_seen_s;

    logic [7:0]          din_r, din_s;
    logic [RAM_AW-1:0]   ada_r, ada_s;
    logic                cea_r, cea_s;
    logic                ceb_r, ceb_s;
    logic [RAM_AW-1:0]   adb_r, adb_s;
    logic [VRAM_AW-1:0]  v_ada_r, v_ada_s;
    logic                v_cea_r, v_cea_s;
    logic [7:0]          v_din_r, v_din_s;
    logic                halted_r, halted_s;

    logic                vs_rise_s;
    logic [15:0]         len_eff_s;
    logic [7:0]          boot_byte_s;
    logic [8:0]          add_s;
    logic [7:0]          sub_s;
    logic [7:0]          inx_s;

    vsync_sync u_vsync_sync (
        .clk     (clk),
        .rst     (rst),
        .vsync   (vsync),
        .vs_rise (vs_rise_s)
    );

    assign len_eff_s   = (boot_program_length > 16'(BOOT_MAX)) ? 16'(BOOT_MAX) : boot_program_length;
    assign boot_byte_s = boot_program[{boot_cnt_r, 3'b000} +: 8];
    assign add_s       = {1'b0, a_r} + {1'b0, lo_r};
    assign sub_s       = a_r - lo_r;
    assign inx_s       = x_r + 8'd1;

    // Next-state, datapath and next-output logic; read requests are issued
    // whenever the FSM enters the request phase of a read state
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        opnd_idx_s = opnd_idx_r;
        pc_s       = pc_r;
        a_s        = a_r;
        x_s        = x_r;
        z_s        = z_r;
        c_s        = c_r;
        boot_cnt_s = boot_cnt_r;
        opcode_s   = opcode_r;
        lo_s       = lo_r;
        hi_s       = hi_r;
        vs_seen_s  = vs_seen_r | vs_rise_s;
        din_s      = din_r;
        ada_s      = ada_r;
        cea_s      = 1'b0;
        ceb_s      = 1'b0;
        adb_s      = adb_r;
        v_ada_s    = v_ada_r;
        v_cea_s    = 1'b0;
        v_din_s    = v_din_r;
        halted_s   = halted_r;

        case (state_r)
            ST_BOOT: begin
                if (boot_cnt_r < len_eff_s) begin
                    cea_s      = 1'b1;
                    ada_s      = boot_cnt_r[RAM_AW-1:0];
                    din_s      = boot_byte_s;
                    boot_cnt_s = boot_cnt_r + 16'd1;
                end else begin
                    state_s = ST_FETCH;
                    phase_s = 1'b0;
                end
            end

            ST_FETCH: begin
                if (phase_r == 1'b0) begin
                    phase_s = 1'b1;
                end else begin
                    opcode_s   = dout;
                    pc_s       = pc_r + 13'd1;
                    vs_seen_s  = 1'b0;   // only edges after this fetch count for WVS
                    opnd_idx_s = 1'b0;
                    if (op_len(dout) == 2'd0) begin
                        state_s = ST_EXEC;
                    end else begin
                        state_s = ST_OPERAND;
                        phase_s = 1'b0;
                    end
                end
            end

            ST_OPERAND: begin
                if (phase_r == 1'b0) begin
                    phase_s = 1'b1;
                end else begin
                    pc_s = pc_r + 13'd1;
                    if (opnd_idx_r == 1'b0) begin
                        lo_s = dout;
                    end else begin
                        hi_s = dout[4:0];
                    end
                    if ((opnd_idx_r == 1'b0) && (op_len(opcode_r) == 2'd2)) begin
                        opnd_idx_s = 1'b1;
                        phase_s    = 1'b0;
                    end else if (opcode_r == OP_LDA_ABS) begin
                        state_s = ST_MEMRD;
                        phase_s = 1'b0;
                    end else begin
                        // Stores are launched here so the strobe lands in the EXEC cycle,
                        // one cycle ahead of the next fetch request
                        state_s = ST_EXEC;
                        case (opcode_r)
                            OP_STA: begin
                                cea_s = 1'b1;
                                ada_s = {hi_s, lo_s};
                                din_s = a_r;
                            end
                            OP_STV: begin
                                v_cea_s = 1'b1;
                                v_ada_s = {hi_s[1:0], lo_s};
                                v_din_s = a_r;
                            end
                            OP_STVX: begin
                                v_cea_s = 1'b1;
                                v_ada_s = {hi_s[1:0], lo_s} + {2'b00, x_r};
                                v_din_s = a_r;
                            end
                            default: begin
                                cea_s = 1'b0;
                            end
                        endcase
                    end
                end
            end

            ST_MEMRD: begin
                if (phase_r == 1'b0) begin
                    phase_s = 1'b1;
                end else begin
                    a_s     = dout;
                    z_s     = (dout == 8'h00);
                    state_s = ST_FETCH;
                    phase_s = 1'b0;
                end
            end

            ST_EXEC: begin
                state_s = ST_FETCH;
                phase_s = 1'b0;
                case (opcode_r)
                    OP_LDA_IMM: begin
                        a_s = lo_r;
                        z_s = (lo_r == 8'h00);
                    end
                    OP_ADD: begin
                        a_s = add_s[7:0];
                        c_s = add_s[8];
                        z_s = (add_s[7:0] == 8'h00);
                    end
                    OP_SUB: begin
                        a_s = sub_s;
                        c_s = (a_r >= lo_r);
                        z_s = (sub_s == 8'h00);
                    end
                    OP_JMP: begin
                        pc_s = {hi_r, lo_r};
                    end
                    OP_JNZ: begin
                        if (z_r == 1'b0) begin
                            pc_s = {hi_r, lo_r};
                        end else begin
                            pc_s = pc_r;
                        end
                    end
                    OP_JC: begin
                        if (c_r == 1'b1) begin
                            pc_s = {hi_r, lo_r};
                        end else begin
                            pc_s = pc_r;
                        end
                    end
                    OP_WVS: begin
                        state_s = ST_WAITVS;
                    end
                    OP_LDX: begin
                        x_s = lo_r;
                    end
                    OP_INX: begin
                        x_s = inx_s;
                        z_s = (inx_s == 8'h00);
                    end
                    OP_HLT: begin
                        state_s  = ST_HALT;
                        halted_s = 1'b1;
                    end
                    default: begin
                        pc_s = pc_r;
                    end
                endcase
            end

            ST_WAITVS: begin
                if (vs_seen_r || vs_rise_s) begin
                    state_s = ST_FETCH;
                    phase_s = 1'b0;
                end else begin
                    state_s = ST_WAITVS;
                end
            end

            ST_HALT: begin
                state_s  = ST_HALT;
                halted_s = 1'b1;
            end

            default: begin
                state_s  = ST_HALT;
                halted_s = 1'b1;
            end
        endcase

        if (((state_s == ST_FETCH) || (state_s == ST_OPERAND) || (state_s == ST_MEMRD))
            && (phase_s == 1'b0)) begin
            ceb_s = 1'b1;
            adb_s = (state_s == ST_MEMRD) ? {hi_s, lo_s} : pc_s;
        end else begin
            ceb_s = 1'b0;
        end
    end

    // Architectural state, FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_BOOT;
            phase_r    <= 1'b0;
            opnd_idx_r <= 1'b0;
            pc_r       <= 13'd0;
            a_r        <= 8'h00;
            x_r        <= 8'h00;
            z_r        <= 1'b0;
            c_r        <= 1'b0;
            boot_cnt_r <= 16'd0;
            opcode_r   <= 8'h00;
            lo_r       <= 8'h00;
            hi_r       <= 5'd0;
            vs_seen_r  <= 1'b0;
            din_r      <= 8'h00;
            ada_r      <= 13'd0;
            cea_r      <= 1'b0;
            ceb_r      <= 1'b0;
            adb_r      <= 13'd0;
            v_ada_r    <= 10'd0;
            v_cea_r    <= 1'b0;
            v_din_r    <= 8'h00;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            opnd_idx_r <= opnd_idx_s;
            pc_r       <= pc_s;
            a_r        <= a_s;
            x_r        <= x_s;
            z_r        <= z_s;
            c_r        <= c_s;
            boot_cnt_r <= boot_cnt_s;
            opcode_r   <= opcode_s;
            lo_r       <= lo_s;
            hi_r       <= hi_s;
            vs_seen_r  <= vs_seen_s;
            din_r      <= din_s;
            ada_r      <= ada_s;
            cea_r      <= cea_s;
            ceb_r      <= ceb_s;
            adb_r      <= adb_s;
            v_ada_r    <= v_ada_s;
            v_cea_r    <= v_cea_s;
            v_din_r    <= v_din_s;
            halted_r   <= halted_s;
        end
    end

    assign din    = din_r;
    assign ada    = ada_r;
    assign cea    = cea_r;
    assign ceb    = ceb_r;
    assign adb    = adb_r;
    assign v_ada  = v_ada_r;
    assign v_cea  = v_cea_r;
    assign v_din  = v_din_r;
    assign halted = halted_r;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: a BSRAM model answers reads one cycle after
// ceb, a negedge monitor logs every write strobe, and short hand-assembled
// programs are checked against hand-computed write traces.
module tb_cpu_core;

    localparam int BOOT_MAX = 256;

    typedef struct {
        int a;
        int d;
        int c;
    } ev_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [7:0]            dout = 8'h00;
    logic                  vsync = 1'b0;
    logic [8*BOOT_MAX-1:0] boot_program = '0;
    logic [15:0]           boot_program_length = 16'd0;
    logic [7:0]            din;
    logic [12:0]           ada;
    logic                  cea;
    logic                  ceb;
    logic [12:0]           adb;
    logic [9:0]            v_ada;
    logic                  v_cea;
    logic [7:0]            v_din;
    logic                  halted;

    logic [7:0] mem [0:8191];
    logic [7:0] prog_q [$];
    ev_t        cea_q [$];
    ev_t        v_q [$];
    int         cyc;
    int         first_ceb_cyc;
    int         first_adb;
    int         n_total = 0;
    int         n_bad = 0;

    cpu_core #(.BOOT_MAX(BOOT_MAX)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dout                (dout),
        .vsync               (vsync),
        .boot_program        (boot_program),
        .boot_program_length (boot_program_length),
        .din                 (din),
        .ada                 (ada),
        .cea                 (cea),
        .ceb                 (ceb),
        .adb                 (adb),
        .v_ada               (v_ada),
        .v_cea               (v_cea),
        .v_din               (v_din),
        .halted              (halted)
    );

    always #5 clk = ~clk;

    // Simple dual-port BSRAM model: port A write, port B read with one cycle latency
    always @(posedge clk) begin
        if (cea) mem[ada] <= din;
        if (ceb) dout <= mem[adb];
    end

    // Strobe monitor: logs writes with the cycle number counted from reset release
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
            first_ceb_cyc = -1;
            first_adb = -1;
            cea_q.delete();
            v_q.delete();
        end else begin
            cyc = cyc + 1;
            if (cea) cea_q.push_back('{int'(ada), int'(din), cyc});
            if (v_cea) v_q.push_back('{int'(v_ada), int'(v_din), cyc});
            if (ceb && (first_ceb_cyc < 0)) begin
                first_ceb_cyc = cyc;
                first_adb = int'(adb);
            end
        end
    end

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_total = n_total + 1;
        if (obs != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_prog(input int len);
        boot_program = '0;
        for (int i = 0; i < prog_q.size(); i++) boot_program[8*i +: 8] = prog_q[i];
        boot_program_length = 16'(len);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n;
        n = 0;
        while ((halted !== 1'b1) && (n < budget)) begin
            @(negedge clk);
            n = n + 1;
        end
        @(negedge clk);
        #1;
        chk_eq({tag, "_halted"}, int'(halted === 1'b1), 1);
    endtask

    initial begin
        int errs;
        int n;
        int d;

        // Reset state: every output low
        repeat (3) @(negedge clk);
        chk_eq("reset_outs", int'(|{din, ada, cea, ceb, adb, v_ada, v_cea, v_din, halted}), 0);

        // Boot copy then LDA #2A; STA 0x0100; HLT
        prog_q = '{8'h01, 8'h2A, 8'h03, 8'h00, 8'h01, 8'hFF};
        load_prog(6);
        do_reset();
        wait_halt("boot", 300);
        chk_eq("boot_cea_count", cea_q.size(), 7);
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < cea_q.size()) begin
                if ((cea_q[i].a != i) || (cea_q[i].d != int'(prog_q[i])) || (cea_q[i].c != i + 1)) errs++;
            end else begin
                errs++;
            end
        end
        chk_eq("boot_seq", errs, 0);
        chk_eq("boot_fetch_cyc", first_ceb_cyc, 7);
        chk_eq("boot_fetch_adb", first_adb, 0);
        if (cea_q.size() > 6) begin
            chk_eq("boot_sta_ada", cea_q[6].a, 'h100);
            chk_eq("boot_sta_din", cea_q[6].d, 'h2A);
        end

        // Load/store round trip, Z cleared by LDA abs
        prog_q = '{8'h01, 8'h2A, 8'h03, 8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01,
                   8'h09, 8'h00, 8'h00, 8'h07, 8'h13, 8'h00, 8'h09, 8'h01, 8'h00, 8'hFF};
        load_prog(20);
        do_reset();
        wait_halt("ldst", 500);
        chk_eq("ldst_cea_count", cea_q.size(), 21);
        if (cea_q.size() > 20) begin
            chk_eq("ldst_sta_ada", cea_q[20].a, 'h100);
            chk_eq("ldst_sta_din", cea_q[20].d, 'h2A);
        end
        chk_eq("ldst_ram", int'(mem[13'h100]), 'h2A);
        chk_eq("ldst_v_count", v_q.size(), 1);
        if (v_q.size() > 0) begin
            chk_eq("ldst_v_ada", v_q[0].a, 'h000);
            chk_eq("ldst_v_din", v_q[0].d, 'h2A);
        end

        // ADD with carry out, then SUB to zero (C=1, Z=1)
        prog_q = '{8'h01, 8'hF0, 8'h04, 8'h20, 8'h09, 8'h10, 8'h00, 8'h08, 8'h0D, 8'h00,
                   8'h09, 8'hEE, 8'h00, 8'h07, 8'h13, 8'h00, 8'h09, 8'hEF, 8'h00, 8'h05,
                   8'h10, 8'h09, 8'h11, 8'h00, 8'h07, 8'h1E, 8'h00, 8'h08, 8'h21, 8'h00,
                   8'h09, 8'hE0, 8'h00, 8'hFF};
        load_prog(34);
        do_reset();
        wait_halt("arith", 800);
        chk_eq("arith_v_count", v_q.size(), 2);
        if (v_q.size() > 1) begin
            chk_eq("arith_add_ada", v_q[0].a, 'h010);
            chk_eq("arith_add_val", v_q[0].d, 'h10);
            chk_eq("arith_sub_ada", v_q[1].a, 'h011);
            chk_eq("arith_sub_val", v_q[1].d, 'h00);
        end

        // SUB with borrow: 05-06 = FF, C=0 so JC falls through
        prog_q = '{8'h01, 8'h05, 8'h05, 8'h06, 8'h09, 8'h20, 8'h00, 8'h08, 8'h0D, 8'h00,
                   8'h09, 8'h21, 8'h00, 8'hFF};
        load_prog(14);
        do_reset();
        wait_halt("borrow", 500);
        chk_eq("borrow_v_count", v_q.size(), 2);
        if (v_q.size() > 1) begin
            chk_eq("borrow_val", v_q[0].d, 'hFF);
            chk_eq("borrow_nc_ada", v_q[1].a, 'h021);
        end

        // WVS: an edge during boot is ignored; STV follows the next edge
        prog_q = '{8'h0A, 8'h09, 8'h05, 8'h00, 8'hFF};
        load_prog(5);
        vsync = 1'b1;
        do_reset();
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk_eq("wvs_no_early", v_q.size(), 0);
        @(negedge clk);
        #1;
        d = cyc;
        vsync = 1'b1;
        n = 0;
        while ((v_q.size() == 0) && (n < 40)) begin
            @(negedge clk);
            #1;
            n = n + 1;
            if (n == 5) vsync = 1'b0;
        end
        chk_eq("wvs_seen", int'(v_q.size() > 0), 1);
        if (v_q.size() > 0) begin
            d = v_q[0].c - d;
            chk_eq("wvs_latency_ok", int'((d >= 8) && (d <= 12)), 1);
            chk_eq("wvs_v_ada", v_q[0].a, 'h005);
            chk_eq("wvs_v_din", v_q[0].d, 'h00);
        end
        vsync = 1'b0;
        wait_halt("wvs", 200);

        // X-indexed VRAM loop, then STVX wrap within 1 KB
        prog_q = '{8'h0B, 8'h00, 8'h01, 8'h41, 8'h0D, 8'h00, 8'h00, 8'h0C, 8'h07, 8'h04,
                   8'h00, 8'h0B, 8'h05, 8'h0D, 8'hFE, 8'h03, 8'hFF};
        load_prog(17);
        do_reset();
        wait_halt("loop", 6000);
        chk_eq("loop_v_count", v_q.size(), 257);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < v_q.size()) begin
                if ((v_q[i].a != i) || (v_q[i].d != 'h41)) errs++;
            end else begin
                errs++;
            end
        end
        chk_eq("loop_seq", errs, 0);
        if (v_q.size() > 256) chk_eq("stvx_wrap_ada", v_q[256].a, 'h003);

        // Asynchronous reset in the middle of the loop, then reboot from address 0
        do_reset();
        n = 0;
        while ((v_q.size() < 10) && (n < 2000)) begin
            @(negedge clk);
            #1;
            n = n + 1;
        end
        chk_eq("mid_progress", int'(v_q.size() >= 10), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_eq("mid_rst_outs", int'(|{din, ada, cea, ceb, adb, v_ada, v_cea, v_din, halted}), 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_eq("reboot_started", int'(cea_q.size() > 0), 1);
        if (cea_q.size() > 0) begin
            chk_eq("reboot_ada", cea_q[0].a, 0);
            chk_eq("reboot_din", cea_q[0].d, 'h0B);
            chk_eq("reboot_cyc", cea_q[0].c, 1);
        end
        wait_halt("reboot", 6000);

        // Zero-length image: no copy, executes what RAM already holds
        boot_program_length = 16'd0;
        do_reset();
        wait_halt("len0", 6000);
        chk_eq("len0_cea_count", cea_q.size(), 0);
        chk_eq("len0_fetch_cyc", first_ceb_cyc, 1);
        chk_eq("len0_v_count", v_q.size(), 257);

        // Oversized length is clamped to BOOT_MAX bytes
        prog_q.delete();
        for (int i = 0; i < BOOT_MAX; i++) prog_q.push_back(8'hFF);
        load_prog(16'hFFFF);
        do_reset();
        wait_halt("clamp", 600);
        chk_eq("clamp_cea_count", cea_q.size(), BOOT_MAX);
        if (cea_q.size() > 0) chk_eq("clamp_last_ada", cea_q[cea_q.size()-1].a, BOOT_MAX - 1);
        chk_eq("clamp_fetch_cyc", first_ceb_cyc, BOOT_MAX + 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
